// File: rtl/enc8b10b_pkg.sv
// enc8b10b_pkg: shared widths, comma symbols and disparity encoding for the 8b10b path
package enc8b10b_pkg;
    localparam int SYMBOL_W = 10;
    localparam logic [SYMBOL_W-1:0] K28_5_NEG = 10'b0011111010;
    localparam logic [SYMBOL_W-1:0] K28_5_POS = 10'b1100000101;
    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;
endpackage

// File: rtl/symbol_disparity.sv
// symbol_disparity: classifies a 10-bit symbol by its ones count
module symbol_disparity
    import enc8b10b_pkg::*;
(
    input  logic [SYMBOL_W-1:0] i_symbol,
    output logic                is_neutral,
    output logic                is_pos2,
    output logic                is_neg2,
    output logic                invalid
);
    logic [3:0] ones;

    // population count of the symbol
    always_comb begin
        ones = '0;
        for (int i = 0; i < SYMBOL_W; i++) ones = ones + {3'b0, i_symbol[i]};
    end

    assign is_neutral = ones == 4'd5;
    assign is_pos2    = ones == 4'd6;
    assign is_neg2    = ones == 4'd4;
    assign invalid    = !(is_neutral || is_pos2 || is_neg2);
endmodule

// File: rtl/ten_bit_serializer.sv
// ten_bit_serializer: shifts 10-bit symbols out MSB (bit a) first, filling gaps with K28.5 idles
module ten_bit_serializer
    import enc8b10b_pkg::*;
#(
    parameter logic [SYMBOL_W-1:0] IDLE_NEG = K28_5_NEG,
    parameter logic [SYMBOL_W-1:0] IDLE_POS = K28_5_POS
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    input  logic [SYMBOL_W-1:0] i_SYMBOL,
    input  logic                i_VALID,
    input  logic                i_ERR_CLR,
    output logic                o_READY,
    output logic                o_SER,
    output logic                o_SYMBOL_START,
    output logic                o_IDLE,
    output logic                o_RD,
    output logic                o_DISP_ERR
);
    logic [SYMBOL_W-1:0] sr_q, sr_d, load_sym;
    logic [3:0]          cnt_q, cnt_d;
    logic                rd_q, rd_d, idle_q, idle_d, err_q, err_d;
    logic                load, is_neutral, is_pos2, is_neg2, invalid, err_set;

    assign load     = cnt_q == 4'd9;
    assign load_sym = i_VALID ? i_SYMBOL : (rd_q == RD_POS ? IDLE_POS : IDLE_NEG);

    symbol_disparity u_disp (
        .i_symbol  (load_sym),
        .is_neutral(is_neutral),
        .is_pos2   (is_pos2),
        .is_neg2   (is_neg2),
        .invalid   (invalid)
    );

    assign err_set = load && (invalid || (is_pos2 && rd_q == RD_POS) || (is_neg2 && rd_q == RD_NEG));

    // next state: shift or load, disparity bookkeeping on load slots, sticky error with set priority
    always_comb begin
        cnt_d  = load ? 4'd0 : cnt_q + 4'd1;
        sr_d   = load ? load_sym : {sr_q[SYMBOL_W-2:0], 1'b0};
        idle_d = load ? !i_VALID : idle_q;
        rd_d   = (load && !is_neutral) ? (is_pos2 ? RD_POS : is_neg2 ? RD_NEG : rd_q) : rd_q;
        err_d  = err_set || (err_q && !i_ERR_CLR);
    end

    // state registers; reset parks the counter on the load slot
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            cnt_q  <= 4'd9;
            sr_q   <= '0;
            rd_q   <= RD_NEG;
            idle_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            rd_q   <= rd_d;
            idle_q <= idle_d;
            err_q  <= err_d;
        end
    end

    assign o_READY        = load;
    assign o_SER          = sr_q[SYMBOL_W-1];
    assign o_SYMBOL_START = cnt_q == 4'd0;
    assign o_IDLE         = idle_q;
    assign o_RD           = rd_q;
    assign o_DISP_ERR     = err_q;
endmodule

// File: tb/tb_ten_bit_serializer.sv
// tb_ten_bit_serializer: randomized bench against a symbol-queue model of the serializer
module tb_ten_bit_serializer;
    localparam logic [9:0] NEG = 10'b0011111010;
    localparam logic [9:0] POS = 10'b1100000101;
    localparam logic [9:0] D0  = 10'b1001110100;

    logic       clk = 1'b0;
    logic       rst, valid, clr;
    logic [9:0] sym;
    logic       o_READY, o_SER, o_SYMBOL_START, o_IDLE, o_RD, o_DISP_ERR;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    // model state: queue of pending {bit, start, idle} entries, running disparity, sticky error
    logic [2:0] q[$];
    logic [2:0] m_out = '0;
    logic       m_rd = 1'b0, m_err = 1'b0;

    always #5 clk = ~clk;

    ten_bit_serializer dut (
        .i_CLK(clk), .i_RST(rst), .i_SYMBOL(sym), .i_VALID(valid), .i_ERR_CLR(clr),
        .o_READY(o_READY), .o_SER(o_SER), .o_SYMBOL_START(o_SYMBOL_START),
        .o_IDLE(o_IDLE), .o_RD(o_RD), .o_DISP_ERR(o_DISP_ERR)
    );

    // reference model: a new symbol is taken whenever the previous one has been fully emitted
    initial forever begin
        logic [9:0] s;
        logic       idl, set;
        int         n;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_rd  = 1'b0;
            m_err = 1'b0;
            m_out = '0;
        end else begin
            set = 1'b0;
            if (q.size() == 0) begin
                idl = !valid;
                s   = valid ? sym : (m_rd ? POS : NEG);
                n   = $countones(s);
                if (n == 6) begin
                    set  = m_rd;
                    m_rd = 1'b1;
                end else if (n == 4) begin
                    set  = !m_rd;
                    m_rd = 1'b0;
                end else if (n != 5) set = 1'b1;
                for (int k = 0; k < 10; k++) q.push_back({s[9-k], k == 0, idl});
            end
            m_err = set || (m_err && !clr);
            m_out = q.pop_front();
        end
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_on)
            check("cycle", 40'({o_READY, o_SER, o_SYMBOL_START, o_IDLE, o_RD, o_DISP_ERR}),
                  40'({q.size() == 0, m_out, m_rd, m_err}));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_READY && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", 40'(o_READY), 40'(1));
    endtask

    task automatic send(input logic [9:0] s);
        wait_ready();
        valid = 1'b1;
        sym   = s;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [39:0] bits;
        logic [29:0] b30, st30;
        logic [3:0]  rds;
        logic        idle_all, any_a, any_b;
        rst = 1'b1; valid = 1'b0; clr = 1'b0; sym = '0;
        tick();
        chk_on = 1;
        tick();
        check("reset_state", 40'({o_READY, o_SER, o_SYMBOL_START, o_IDLE, o_RD, o_DISP_ERR}), 40'(6'b100000));
        rst = 1'b0;
        idle_all = 1'b1; any_a = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            bits[39-i] = o_SER;
            if (i % 10 == 0) rds[3-i/10] = o_RD;
            idle_all &= o_IDLE;
            any_a |= o_DISP_ERR;
        end
        check("idle_bits", bits, {NEG, POS, NEG, POS});
        check("idle_rd", 40'(rds), 40'(4'b1010));
        check("idle_flag", 40'(idle_all), 40'(1));
        check("idle_err", 40'(any_a), 40'(0));
        valid = 1'b1; sym = D0;
        any_a = 1'b0; any_b = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            b30[29-i]  = o_SER;
            st30[29-i] = o_SYMBOL_START;
            any_a |= o_RD;
            any_b |= o_IDLE;
        end
        valid = 1'b0;
        check("b2b_bits", 40'(b30), 40'({D0, D0, D0}));
        check("b2b_start", 40'(st30), 40'({3{10'b1000000000}}));
        check("b2b_rd", 40'(any_a), 40'(0));
        check("b2b_idle", 40'(any_b), 40'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(NEG);
        check("first_neg", 40'({o_DISP_ERR, o_RD}), 40'(2'b01));
        send(NEG);
        check("disp_violation", 40'({o_DISP_ERR, o_RD}), 40'(2'b11));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("err_clear", 40'(o_DISP_ERR), 40'(0));
        send(10'b0000000011);
        check("invalid_weight", 40'({o_DISP_ERR, o_RD}), 40'(2'b11));
        wait_ready();
        tick();
        tick(); tick(); tick();
        valid = 1'b1; sym = D0;
        wait_ready();
        tick();
        valid = 1'b0;
        check("late_valid", 40'({o_SYMBOL_START, o_IDLE, o_SER}), 40'(3'b101));
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_reset", 40'({o_SER, o_RD, o_READY}), 40'(3'b001));
        tick();
        check("post_reset_idle", 40'({o_SER, o_SYMBOL_START, o_IDLE}), 40'(3'b011));
        for (int i = 0; i < 2000; i++) begin
            valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: sym = D0;
                1: sym = NEG;
                2: sym = POS;
                default: sym = 10'($urandom);
            endcase
            clr = $urandom_range(0, 15) == 0;
            rst = $urandom_range(0, 199) == 0;
            tick();
        end
        rst = 1'b0; valid = 1'b0; clr = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
